// File: rtl/multiplier_sequencer.sv
// Purpose : unsigned shift-add multiplier that reuses one partial-product row.
//           The row adds one multiplier bit per cycle into an accumulator.
// Latency : start sampled in cycle 0 -> outValid in cycle Q_WIDTH+1.
// Backpr. : the product is held in HOLD until outReady. A start in CALC, or in
//           HOLD without outReady, is ignored. Back-to-back is allowed on the
//           handshake edge.
// Ports   : clock, resetN (sync, active-low)
//           start, mIn, qIn                  - operand request
//           busy, outValid, outReady, product - status and result handshake
module multiplier_sequencer #(
    parameter int M_WIDTH = 2,
    parameter int Q_WIDTH = 3
) (
    input  logic                       clock,
    input  logic                       resetN,
    input  logic                       start,
    input  logic [M_WIDTH-1:0]         mIn,
    input  logic [Q_WIDTH-1:0]         qIn,
    output logic                       busy,
    output logic                       outValid,
    input  logic                       outReady,
    output logic [M_WIDTH+Q_WIDTH-1:0] product
);

    localparam int P_WIDTH = M_WIDTH + Q_WIDTH;
    localparam int C_WIDTH = $clog2(Q_WIDTH) + 1;

    localparam logic [C_WIDTH-1:0] LAST_COUNT = C_WIDTH'(Q_WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]         state;
    logic [C_WIDTH-1:0] count;
    logic [P_WIDTH-1:0] acc;
    // The multiplicand is pre-shifted and the multiplier is consumed from the
    // LSB. On each CALC edge, m_sh equals m << count and q_sh[0] equals
    // q[count]. This avoids a variable shifter and a variable bit-select.
    logic [P_WIDTH-1:0] m_sh;
    logic [Q_WIDTH-1:0] q_sh;
    logic [P_WIDTH-1:0] row;

    // The shared partial-product row: an AND-gate row feeding the adder.
    assign row = q_sh[0] ? m_sh : '0;

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state <= IDLE;
            count <= '0;
            acc   <= '0;
            m_sh  <= '0;
            q_sh  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m_sh  <= P_WIDTH'(mIn);
                        q_sh  <= qIn;
                        acc   <= '0;
                        count <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc   <= acc + row;
                    m_sh  <= m_sh << 1;
                    q_sh  <= q_sh >> 1;
                    count <= count + C_WIDTH'(1);
                    if (count == LAST_COUNT) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (outReady) begin
                        if (start) begin
                            // Back-to-back: the handshake edge also accepts
                            // the next operand pair.
                            m_sh  <= P_WIDTH'(mIn);
                            q_sh  <= qIn;
                            acc   <= '0;
                            count <= '0;
                            state <= CALC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The outputs decode only flops, so no input reaches an output in the
    // same cycle.
    assign busy     = (state == CALC) || (state == HOLD);
    assign outValid = (state == HOLD);
    assign product  = acc;

endmodule

// File: tb/tb_multiplier_sequencer.sv
module tb_multiplier_sequencer;

    localparam int M = 2;
    localparam int Q = 3;
    localparam int P = M + Q;
    localparam int LAT = Q + 1;

    logic         clock = 1'b0;
    logic         resetN;
    logic         start;
    logic [M-1:0] mIn;
    logic [Q-1:0] qIn;
    logic         busy;
    logic         outValid;
    logic         outReady;
    logic [P-1:0] product;

    int checks = 0;
    int errors = 0;

    multiplier_sequencer #(.M_WIDTH(M), .Q_WIDTH(Q)) dut (
        .clock    (clock),
        .resetN   (resetN),
        .start    (start),
        .mIn      (mIn),
        .qIn      (qIn),
        .busy     (busy),
        .outValid (outValid),
        .outReady (outReady),
        .product  (product)
    );

    always #5 clock = ~clock;

    // Advances one cycle. Outputs are sampled, and inputs driven, 1 ns after
    // the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Presents operands with start in the current cycle. The scrambled
    // operands afterwards show that the operands were captured.
    task automatic launch(input int m, input int q);
        start = 1'b1;
        mIn   = M'(m);
        qIn   = Q'(q);
        step();
        start = 1'b0;
        mIn   = M'($urandom);
        qIn   = Q'($urandom);
    endtask

    // Called in cycle 1 of an operation. Returns the cycle index in which
    // outValid was first seen, or 50 on timeout.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!outValid && lat < 50) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        step();
        step();
        checks++;
        if (busy !== 1'b0 || outValid !== 1'b0 || product !== '0) begin
            errors++;
            $display("FAIL reset: busy=%b outValid=%b product=%0d, need 0/0/0", busy, outValid, product);
        end
        resetN = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int lat;
        outReady = 1'b1;
        launch(3, 5);
        checks++;
        if (busy !== 1'b1 || outValid !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy: busy=%b outValid=%b, need 1/0", busy, outValid);
        end
        wait_valid(lat);
        checks++;
        if (lat != LAT) begin
            errors++;
            $display("FAIL basic_latency: got %0d need %0d", lat, LAT);
        end
        checks++;
        if (product !== P'(15)) begin
            errors++;
            $display("FAIL basic_product: got %0d need 15", product);
        end
        step();
        checks++;
        if (busy !== 1'b0 || outValid !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: busy=%b outValid=%b, need 0/0", busy, outValid);
        end
    endtask

    task automatic test_max_zero();
        int ms[2] = '{3, 0};
        int lat;
        outReady = 1'b1;
        foreach (ms[i]) begin
            launch(ms[i], 7);
            wait_valid(lat);
            checks++;
            if (lat != LAT || product !== P'(ms[i] * 7)) begin
                errors++;
                $display("FAIL max_zero m=%0d: lat=%0d product=%0d, need lat=%0d product=%0d",
                         ms[i], lat, product, LAT, ms[i] * 7);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        outReady = 1'b0;
        launch(2, 6);
        wait_valid(lat);
        checks++;
        if (lat != LAT || product !== P'(12)) begin
            errors++;
            $display("FAIL bp_first: lat=%0d product=%0d, need %0d/12", lat, product, LAT);
        end
        for (int i = 0; i < 5; i++) begin
            start = 1'($urandom);
            mIn   = M'($urandom);
            qIn   = Q'($urandom);
            step();
            checks++;
            if (outValid !== 1'b1 || product !== P'(12)) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: outValid=%b product=%0d, need 1/12", i, outValid, product);
            end
        end
        start    = 1'b0;
        outReady = 1'b1;
        step();
        checks++;
        if (outValid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: outValid=%b busy=%b, need 0/0", outValid, busy);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        outReady = 1'b0;
        launch(3, 5);
        wait_valid(lat);
        checks++;
        if (product !== P'(15)) begin
            errors++;
            $display("FAIL b2b_first: got %0d need 15", product);
        end
        outReady = 1'b1;
        launch(1, 3);
        checks++;
        if (busy !== 1'b1 || outValid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_transition: busy=%b outValid=%b, need 1/0", busy, outValid);
        end
        wait_valid(lat);
        checks++;
        if (lat != LAT || product !== P'(3)) begin
            errors++;
            $display("FAIL b2b_second: lat=%0d product=%0d, need %0d/3", lat, product, LAT);
        end
        step();
    endtask

    task automatic test_busy_ignore();
        int lat;
        int seen;
        outReady = 1'b1;
        launch(3, 5);
        step();
        start = 1'b1;
        mIn   = M'(1);
        qIn   = Q'(1);
        step();
        start = 1'b0;
        lat   = 3;
        while (!outValid && lat < 50) begin
            step();
            lat++;
        end
        checks++;
        if (lat != LAT || product !== P'(15)) begin
            errors++;
            $display("FAIL busy_ignore: lat=%0d product=%0d, need %0d/15", lat, product, LAT);
        end
        seen = 0;
        repeat (8) begin
            step();
            if (outValid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL busy_ignore_extra: %0d extra valid cycles, need 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        outReady = 1'b1;
        launch(3, 5);
        step();
        resetN = 1'b0;
        step();
        resetN = 1'b1;
        checks++;
        if (busy !== 1'b0 || outValid !== 1'b0 || product !== '0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b outValid=%b product=%0d, need 0/0/0", busy, outValid, product);
        end
        seen = 0;
        repeat (6) begin
            step();
            if (outValid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_mid_stale: %0d valid cycles, need 0", seen);
        end
        launch(2, 3);
        wait_valid(lat);
        checks++;
        if (lat != LAT || product !== P'(6)) begin
            errors++;
            $display("FAIL reset_mid_after: lat=%0d product=%0d, need %0d/6", lat, product, LAT);
        end
        step();
    endtask

    // Reference model: every product is m*q. It is ready LAT cycles after
    // acceptance and held through any stall. Each result ends either with a
    // plain handshake or with a back-to-back launch.
    task automatic test_random();
        int m;
        int q;
        int lat;
        int stall;
        bit in_hold = 1'b0;
        for (int i = 0; i < 40; i++) begin
            m = int'($urandom_range(0, (1 << M) - 1));
            q = int'($urandom_range(0, (1 << Q) - 1));
            outReady = 1'b1;
            launch(m, q);
            outReady = 1'b0;
            checks++;
            if (busy !== 1'b1 || outValid !== 1'b0) begin
                errors++;
                $display("FAIL rand_accept #%0d (b2b=%0d): busy=%b outValid=%b, need 1/0", i, in_hold, busy, outValid);
            end
            wait_valid(lat);
            checks++;
            if (lat != LAT || product !== P'(m * q)) begin
                errors++;
                $display("FAIL rand_result #%0d %0dx%0d: lat=%0d product=%0d, need %0d/%0d",
                         i, m, q, lat, product, LAT, m * q);
            end
            stall = int'($urandom_range(0, 3));
            repeat (stall) begin
                start = 1'($urandom);
                step();
            end
            start = 1'b0;
            checks++;
            if (outValid !== 1'b1 || product !== P'(m * q)) begin
                errors++;
                $display("FAIL rand_stall #%0d: outValid=%b product=%0d, need 1/%0d", i, outValid, product, m * q);
            end
            if ($urandom_range(0, 1) == 1) begin
                in_hold = 1'b1;
            end else begin
                outReady = 1'b1;
                step();
                outReady = 1'b0;
                in_hold  = 1'b0;
                checks++;
                if (outValid !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_drain #%0d: outValid=%b busy=%b, need 0/0", i, outValid, busy);
                end
            end
        end
        if (in_hold) begin
            outReady = 1'b1;
            step();
        end
    endtask

    initial begin
        resetN   = 1'b0;
        start    = 1'b0;
        outReady = 1'b0;
        mIn      = '0;
        qIn      = '0;
        test_reset();
        test_basic();
        test_max_zero();
        test_backpressure();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
